speck_axi_lite_slave_regs: RTL and testbench

- AXI4-Lite slave (responder) register file that fronts the Speck multirate cipher core.
- The AXI4-Lite master BFM and the PS drive it: they load key and plaintext, start the core, poll status and read the result.
- Decodes 32-bit word-aligned accesses, applies WSTRB byte enables, generates start/key-load pulses, and captures core done/output.

---
 rtl/speck_axi_lite_slave_regs.sv | 157 +++++++++++++++
 tb/tb_speck_axi_lite_slave_regs.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speck_axi_lite_slave_regs.sv
// speck_axi_lite_slave_regs: AXI4-Lite register file fronting the Speck core; `SPECK_AXI_SLVERR_EN enables SLVERR responses
module speck_axi_lite_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [127:0]                    core_key,
    output logic [63:0]                     core_din,
    output logic                            core_decrypt,
    output logic                            core_start,
    output logic                            core_key_load,
    input  logic                            core_busy,
    input  logic                            core_done,
    input  logic [63:0]                     core_dout
);
    logic        aw_full, w_full, aw_full_n, w_full_n, bvalid_n, rvalid_n;
    logic [3:0]  aw_idx_q, w_strb_q, wr_idx, rd_idx, wr_strb;
    logic [31:0] w_data_q, wr_data, rd_val;
    logic        aw_hs, w_hs, ar_hs, commit, wr_en, wr_err, rd_err;
    logic        ctrl_wr, start_req, clr_st;
    logic [31:0] key [4];
    logic [31:0] din [2];
    logic [63:0] dout;
    logic        decrypt, done_st, err_st, rd_status;
    logic        unused;

    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
    // a write may commit on the very edge its last half is handshaked
    assign commit  = (aw_full | aw_hs) & (w_full | w_hs) & ~S_AXI_BVALID;
    assign wr_idx  = aw_full ? aw_idx_q : S_AXI_AWADDR[5:2];
    assign wr_data = w_full ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_full ? w_strb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[5:2];

    assign aw_full_n = ~commit & (aw_full | aw_hs);
    assign w_full_n  = ~commit & (w_full | w_hs);
    assign bvalid_n  = commit | (S_AXI_BVALID & ~S_AXI_BREADY);
    assign rvalid_n  = ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY);

`ifdef SPECK_AXI_SLVERR_EN
    assign wr_err = (wr_idx == 4'd1) || (wr_idx >= 4'd8);
    assign rd_err = rd_idx >= 4'd10;
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    assign wr_en     = commit & ~wr_err;
    assign ctrl_wr   = wr_en && wr_idx == 4'd0 && wr_strb[0];
    assign start_req = ctrl_wr & wr_data[0];
    assign clr_st    = S_AXI_RVALID & S_AXI_RREADY & rd_status;

    assign core_key     = {key[3], key[2], key[1], key[0]};
    assign core_din     = {din[1], din[0]};
    assign core_decrypt = decrypt;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        rd_val = '0;
        case (rd_idx)
            4'd0:                      rd_val = {30'd0, decrypt, 1'b0};
            4'd1:                      rd_val = {29'd0, err_st, done_st, core_busy};
            4'd2, 4'd3, 4'd4, 4'd5:    rd_val = key[2'(rd_idx - 4'd2)];
            4'd6, 4'd7:                rd_val = din[rd_idx[0]];
            4'd8:                      rd_val = dout[31:0];
            4'd9:                      rd_val = dout[63:32];
            default:                   rd_val = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
            core_start    <= 1'b0;
            core_key_load <= 1'b0;
            key           <= '{default: '0};
            din           <= '{default: '0};
            dout          <= '0;
            decrypt       <= 1'b0;
            done_st       <= 1'b0;
            err_st        <= 1'b0;
            rd_status     <= 1'b0;
        end else begin
            aw_full       <= aw_full_n;
            w_full        <= w_full_n;
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[5:2];
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            // no new write is accepted while a response is outstanding
            S_AXI_AWREADY <= ~aw_full_n & ~bvalid_n;
            S_AXI_WREADY  <= ~w_full_n & ~bvalid_n;
            S_AXI_BVALID  <= bvalid_n;
            if (commit) S_AXI_BRESP <= wr_err ? 2'b10 : 2'b00;
            core_start    <= start_req & ~core_busy;
            core_key_load <= ctrl_wr & wr_data[2];
            if (ctrl_wr) decrypt <= wr_data[1];
            if (wr_en && wr_idx >= 4'd2 && wr_idx <= 4'd5)
                key[2'(wr_idx - 4'd2)] <= merge(key[2'(wr_idx - 4'd2)], wr_data, wr_strb);
            if (wr_en && wr_idx[3:1] == 3'd3)
                din[wr_idx[0]] <= merge(din[wr_idx[0]], wr_data, wr_strb);
            if (core_done) dout <= core_dout;
            // setting beats a concurrent clearing STATUS read
            done_st       <= core_done | (done_st & ~clr_st);
            err_st        <= (start_req & core_busy) | (err_st & ~clr_st);
            S_AXI_ARREADY <= ~rvalid_n;
            S_AXI_RVALID  <= rvalid_n;
            if (ar_hs) begin
                S_AXI_RDATA <= rd_val;
                S_AXI_RRESP <= rd_err ? 2'b10 : 2'b00;
                rd_status   <= rd_idx == 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_speck_axi_lite_slave_regs.sv
// tb_speck_axi_lite_slave_regs: directed self-checking bench for the Speck AXI4-Lite register file
module tb_speck_axi_lite_slave_regs;
    logic         tb_ACLK = 1'b0;
    logic         aresetn;
    logic [5:0]   awaddr, araddr;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] core_key;
    logic [63:0]  core_din, core_dout;
    logic         core_decrypt, core_start, core_key_load, core_busy, core_done;
    int           n_tests = 0;
    int           n_fail = 0;

`ifdef SPECK_AXI_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    always #5 tb_ACLK = ~tb_ACLK;

    speck_axi_lite_slave_regs dut (
        .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .core_key(core_key), .core_din(core_din), .core_decrypt(core_decrypt),
        .core_start(core_start), .core_key_load(core_key_load),
        .core_busy(core_busy), .core_done(core_done), .core_dout(core_dout)
    );

    // returns on the first falling edge at which BVALID is seen
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
        int t = 0;
        logic aw_go, w_go;
        @(negedge tb_ACLK);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid) && t < 50) begin
            aw_go = awvalid & awready;
            w_go  = wvalid & wready;
            @(negedge tb_ACLK);
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && t < 100) begin
            @(negedge tb_ACLK);
            t++;
        end
        if (!bvalid) begin
            n_tests++; n_fail++;
            $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
        end
        r = bresp;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int t = 0;
        logic go = 1'b0;
        @(negedge tb_ACLK);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!go && t < 50) begin
            go = arready;
            @(negedge tb_ACLK);
            t++;
        end
        arvalid = 1'b0;
        while (!rvalid && t < 100) begin
            @(negedge tb_ACLK);
            t++;
        end
        if (!rvalid) begin
            n_tests++; n_fail++;
            $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
        end
        d = rdata; r = rresp;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        aresetn = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        n_tests++;
        if ({awready, wready, arready, bvalid, rvalid, core_start, core_key_load} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_handshake got=%b required 0000000",
                     {awready, wready, arready, bvalid, rvalid, core_start, core_key_load});
        end
        n_tests++;
        if ({bresp, rresp, rdata, core_key, core_din, core_decrypt} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs bresp=%b rresp=%b rdata=%h key=%h din=%h required all 0",
                     bresp, rresp, rdata, core_key, core_din);
        end
        aresetn = 1'b1;
        @(negedge tb_ACLK);
        n_tests++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++;
            $display("FAIL ready_after_reset got=%b required 111", {awready, wready, arready});
        end
        axi_read(6'h20, d, r);
        n_tests++;
        if (d !== 32'h0 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_dout0 got=%h/%b required 00000000/00", d, r);
        end
    endtask

    task automatic test_key();
        logic [31:0] kv [4];
        logic [31:0] d;
        logic [1:0]  r;
        kv = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(8 + 4 * i), kv[i], 4'hF, r);
            n_tests++;
            if (r !== 2'b00) begin
                n_fail++;
                $display("FAIL key_bresp[%0d] got=%b required 00", i, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(8 + 4 * i), d, r);
            n_tests++;
            if (d !== kv[i] || r !== 2'b00) begin
                n_fail++;
                $display("FAIL key_readback[%0d] got=%h/%b required %h/00", i, d, r, kv[i]);
            end
        end
        n_tests++;
        if (core_key !== 128'hbeef0011dead0011abcd00010101ffff) begin
            n_fail++;
            $display("FAIL core_key got=%h required beef0011dead0011abcd00010101ffff", core_key);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(6'h0C, 32'hFFFFFFFF, 4'hF, r);
        axi_write(6'h0C, 32'h12345678, 4'b0101, r);
        axi_read(6'h0C, d, r);
        n_tests++;
        if (d !== 32'hFF34FF78) begin
            n_fail++;
            $display("FAIL wstrb_merge got=%h required ff34ff78", d);
        end
        axi_write(6'h0C, 32'h00000000, 4'b0000, r);
        axi_read(6'h0C, d, r);
        n_tests++;
        if (d !== 32'hFF34FF78 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL wstrb_zero got=%h/%b required ff34ff78/00", d, r);
        end
    endtask

    task automatic test_w_before_aw();
        @(negedge tb_ACLK);
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge tb_ACLK);
        wvalid = 1'b0;
        n_tests++;
        if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL w_buffered wready=%b awready=%b bvalid=%b required 0/1/0", wready, awready, bvalid);
        end
        repeat (2) @(negedge tb_ACLK);
        awaddr = 6'h10; awvalid = 1'b1;
        @(negedge tb_ACLK);
        awvalid = 1'b0;
        n_tests++;
        if (bvalid !== 1'b1 || core_key[95:64] !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL late_aw_commit bvalid=%b key2=%h required 1/a5a5a5a5", bvalid, core_key[95:64]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_ACLK);
            n_tests++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) begin
                n_fail++;
                $display("FAIL bresp_hold[%0d] bvalid=%b bresp=%b awready=%b required 1/00/0", i, bvalid, bresp, awready);
            end
        end
        bready = 1'b1;
        @(negedge tb_ACLK);
        @(negedge tb_ACLK);
        n_tests++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_commit bvalid=%b awready=%b required 0/1", bvalid, awready);
        end
    endtask

    task automatic test_ctrl();
        logic [31:0] d;
        logic [1:0]  r;
        core_busy = 1'b0;
        axi_write(6'h00, 32'h5, 4'hF, r);
        n_tests++;
        if ({core_start, core_key_load} !== 2'b11) begin
            n_fail++;
            $display("FAIL start_pulse got=%b required 11", {core_start, core_key_load});
        end
        @(negedge tb_ACLK);
        n_tests++;
        if ({core_start, core_key_load} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_one_cycle got=%b required 00", {core_start, core_key_load});
        end
        axi_read(6'h00, d, r);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL ctrl_selfclear got=%h required 00000000", d);
        end
        core_busy = 1'b1;
        axi_write(6'h00, 32'h5, 4'hF, r);
        n_tests++;
        if (core_start !== 1'b0) begin
            n_fail++;
            $display("FAIL start_suppressed got=%b required 0", core_start);
        end
        axi_read(6'h04, d, r);
        n_tests++;
        if (d !== 32'h5) begin
            n_fail++;
            $display("FAIL status_start_err got=%h required 00000005", d);
        end
        core_busy = 1'b0;
        axi_read(6'h04, d, r);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL status_err_cleared got=%h required 00000000", d);
        end
        axi_write(6'h00, 32'h2, 4'hF, r);
        axi_read(6'h00, d, r);
        n_tests++;
        if (d !== 32'h2 || core_decrypt !== 1'b1 || core_start !== 1'b0) begin
            n_fail++;
            $display("FAIL decrypt got=%h/%b/%b required 00000002/1/0", d, core_decrypt, core_start);
        end
    endtask

    task automatic test_done();
        logic [31:0] d;
        logic [1:0]  r;
        int t = 0;
        logic go = 1'b0;
        @(negedge tb_ACLK);
        core_dout = 64'h0123456789ABCDEF; core_done = 1'b1;
        @(negedge tb_ACLK);
        core_done = 1'b0; core_dout = 64'hFFFFFFFFFFFFFFFF;
        axi_read(6'h20, d, r);
        n_tests++;
        if (d !== 32'h89ABCDEF) begin
            n_fail++;
            $display("FAIL dout0 got=%h required 89abcdef", d);
        end
        axi_read(6'h24, d, r);
        n_tests++;
        if (d !== 32'h01234567) begin
            n_fail++;
            $display("FAIL dout1 got=%h required 01234567", d);
        end
        axi_read(6'h04, d, r);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL status_done got=%h required 00000002", d);
        end
        axi_read(6'h04, d, r);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL status_done_cleared got=%h required 00000000", d);
        end
        // raise core_done on the same edge the STATUS read completes
        @(negedge tb_ACLK);
        araddr = 6'h04; arvalid = 1'b1; rready = 1'b1;
        while (!go && t < 50) begin
            go = arready;
            @(negedge tb_ACLK);
            t++;
        end
        arvalid = 1'b0;
        n_tests++;
        if (rvalid !== 1'b1 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL coincident_read rvalid=%b rdata=%h required 1/00000000", rvalid, rdata);
        end
        core_done = 1'b1;
        @(negedge tb_ACLK);
        core_done = 1'b0;
        axi_read(6'h04, d, r);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL done_set_wins got=%h required 00000002", d);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(6'h20, 32'hDEADBEEF, 4'hF, r);
        n_tests++;
        if (r !== ERR_RESP) begin
            n_fail++;
            $display("FAIL ro_write_bresp got=%b required %b", r, ERR_RESP);
        end
        axi_write(6'h30, 32'hCAFEF00D, 4'hF, r);
        n_tests++;
        if (r !== ERR_RESP) begin
            n_fail++;
            $display("FAIL unmapped_write_bresp got=%b required %b", r, ERR_RESP);
        end
        axi_read(6'h30, d, r);
        n_tests++;
        if (d !== 32'h0 || r !== ERR_RESP) begin
            n_fail++;
            $display("FAIL unmapped_read got=%h/%b required 00000000/%b", d, r, ERR_RESP);
        end
        axi_read(6'h20, d, r);
        n_tests++;
        if (d !== 32'hFFFFFFFF || r !== 2'b00) begin
            n_fail++;
            $display("FAIL dout0_unchanged got=%h/%b required ffffffff/00", d, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] r;
        axi_write(6'h18, 32'h11223344, 4'hF, r);
        axi_write(6'h1C, 32'h55667788, 4'hF, r);
        n_tests++;
        if (core_din !== 64'h5566778811223344 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL core_din got=%h/%b required 5566778811223344/00", core_din, r);
        end
    endtask

    initial begin
        aresetn = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
        core_busy = 1'b0; core_done = 1'b0; core_dout = '0;
        test_reset();
        test_key();
        test_strobe();
        test_w_before_aw();
        test_ctrl();
        test_done();
        test_unmapped();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
